// File: rtl/tlb_op_unit_if.sv
// Handshake and CSR bundle between the EX privileged sequencer (master) and
// the TLB maintenance unit (slave).
interface tlb_op_unit_if #(
  parameter int unsigned TLB_NUM = 16
);
  localparam int unsigned IW = $clog2(TLB_NUM);

  logic          tlbsrch_valid;
  logic          tlbrd_valid;
  logic          tlbwr_valid;
  logic          tlbfill_valid;
  logic          invtlb_valid;
  logic          tlbsrch_ready;
  logic          tlbrd_ready;
  logic          tlbwr_ready;
  logic          tlbfill_ready;
  logic          invtlb_ready;
  logic [4:0]    invtlb_op;
  logic [31:0]   invtlb_asid;
  logic [18:0]   invtlb_va;
  logic [31:0]   csr_tlbidx;
  logic [31:0]   csr_tlbehi;
  logic [31:0]   csr_tlbelo0;
  logic [31:0]   csr_tlbelo1;
  logic [9:0]    csr_asid;
  logic [5:0]    csr_estat_ecode;
  logic          srch_wen;
  logic          srch_ne;
  logic [IW-1:0] srch_idx;
  logic          rd_wen;
  logic [31:0]   rd_tlbidx;
  logic [31:0]   rd_tlbehi;
  logic [31:0]   rd_tlbelo0;
  logic [31:0]   rd_tlbelo1;
  logic [9:0]    rd_asid;

  modport master (
    output tlbsrch_valid, tlbrd_valid, tlbwr_valid, tlbfill_valid, invtlb_valid,
    output invtlb_op, invtlb_asid, invtlb_va,
    output csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid, csr_estat_ecode,
    input  tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready,
    input  srch_wen, srch_ne, srch_idx,
    input  rd_wen, rd_tlbidx, rd_tlbehi, rd_tlbelo0, rd_tlbelo1, rd_asid
  );

  modport slave (
    input  tlbsrch_valid, tlbrd_valid, tlbwr_valid, tlbfill_valid, invtlb_valid,
    input  invtlb_op, invtlb_asid, invtlb_va,
    input  csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid, csr_estat_ecode,
    output tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready,
    output srch_wen, srch_ne, srch_idx,
    output rd_wen, rd_tlbidx, rd_tlbehi, rd_tlbelo0, rd_tlbelo1, rd_asid
  );
endinterface

// File: rtl/tlb_op_unit.sv
// TLB entry array plus a multi-cycle engine for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB.
// Searches and invalidations scan one entry per cycle.
module tlb_op_unit #(
  parameter int unsigned TLB_NUM = 16
) (
  input logic          clk,
  input logic          rst,
  tlb_op_unit_if.slave bus
);
  localparam int unsigned IW = $clog2(TLB_NUM);
  localparam logic [IW-1:0] LastIdx = IW'(TLB_NUM - 1);

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } page_t;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    page_t       p0;
    page_t       p1;
  } entry_t;

  typedef enum logic [2:0] {StIdle, StSrchScan, StRd, StWr, StInvScan, StDone} state_e;
  typedef enum logic [2:0] {OpSrch, OpRd, OpWr, OpFill, OpInv} op_e;

  function automatic logic vppn_match(input logic [5:0] ps, input logic [18:0] ev,
                                      input logic [18:0] va);
    if (ps == 6'd21) return ev[18:9] == va[18:9];
    return ev == va;
  endfunction

  function automatic page_t to_page(input logic [31:0] elo);
    return '{ppn: elo[27:8], plv: elo[3:2], mat: elo[5:4], d: elo[1], v: elo[0]};
  endfunction

  function automatic logic [31:0] to_elo(input page_t p, input logic g);
    return {4'b0, p.ppn, 1'b0, g, p.mat, p.plv, p.d, p.v};
  endfunction

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] fill_cnt_q;
  logic          accept;

  // Request fields captured on accept
  logic [IW-1:0] tgt_q;
  logic [5:0]    ps_q;
  logic          ne_q;
  logic [18:0]   vppn_q;
  page_t         p0_q, p1_q;
  logic          g_q;
  logic [9:0]    asid_q;
  logic          force_e_q;
  logic [4:0]    inv_op_q;
  logic [9:0]    inv_asid_q;
  logic [18:0]   inv_va_q;

  entry_t             entry_q [TLB_NUM];
  logic [TLB_NUM-1:0] e_q;

  logic          srch_ne_q;
  logic [IW-1:0] srch_idx_q;
  logic [31:0]   rd_tlbidx_q, rd_tlbehi_q, rd_tlbelo0_q, rd_tlbelo1_q;
  logic [9:0]    rd_asid_q;

  entry_t cur, rd_ent;
  logic   srch_hit, srch_end, inv_hit, asid_eq, va_eq, wr_en, inv_clr, done;

  logic unused_bits;
  assign unused_bits = ^{bus.csr_tlbidx[30], bus.csr_tlbidx[23:IW], bus.csr_tlbehi[12:0],
                         bus.csr_tlbelo0[31:28], bus.csr_tlbelo0[7],
                         bus.csr_tlbelo1[31:28], bus.csr_tlbelo1[7], bus.invtlb_asid[31:10]};

  assign cur      = entry_q[ptr_q];
  assign rd_ent   = entry_q[tgt_q];
  assign srch_hit = e_q[ptr_q] && vppn_match(cur.ps, cur.vppn, vppn_q) &&
                    (cur.g || cur.asid == asid_q);
  assign srch_end = srch_hit || (ptr_q == LastIdx);
  assign asid_eq  = cur.asid == inv_asid_q;
  assign va_eq    = vppn_match(cur.ps, cur.vppn, inv_va_q);

  always_comb begin
    inv_hit = 1'b0;
    case (inv_op_q)
      5'd0, 5'd1: inv_hit = 1'b1;
      5'd2:       inv_hit = cur.g;
      5'd3:       inv_hit = !cur.g;
      5'd4:       inv_hit = !cur.g && asid_eq;
      5'd5:       inv_hit = !cur.g && asid_eq && va_eq;
      5'd6:       inv_hit = (cur.g || asid_eq) && va_eq;
      default:    inv_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        ptr_d = '0;
        // Fixed priority; losing valids in the same cycle are simply dropped
        if (bus.tlbsrch_valid) begin
          state_d = StSrchScan; op_d = OpSrch; accept = 1'b1;
        end else if (bus.tlbrd_valid) begin
          state_d = StRd;       op_d = OpRd;   accept = 1'b1;
        end else if (bus.tlbwr_valid) begin
          state_d = StWr;       op_d = OpWr;   accept = 1'b1;
        end else if (bus.tlbfill_valid) begin
          state_d = StWr;       op_d = OpFill; accept = 1'b1;
        end else if (bus.invtlb_valid) begin
          state_d = StInvScan;  op_d = OpInv;  accept = 1'b1;
        end
      end
      StSrchScan: begin
        if (srch_end) state_d = StDone;
        else          ptr_d   = ptr_q + 1'b1;
      end
      StRd, StWr: state_d = StDone;
      StInvScan: begin
        if (ptr_q == LastIdx) state_d = StDone;
        else                  ptr_d   = ptr_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= OpSrch;
      ptr_q        <= '0;
      fill_cnt_q   <= '0;
      tgt_q        <= '0;
      ps_q         <= '0;
      ne_q         <= 1'b0;
      vppn_q       <= '0;
      p0_q         <= '0;
      p1_q         <= '0;
      g_q          <= 1'b0;
      asid_q       <= '0;
      force_e_q    <= 1'b0;
      inv_op_q     <= '0;
      inv_asid_q   <= '0;
      inv_va_q     <= '0;
      srch_ne_q    <= 1'b0;
      srch_idx_q   <= '0;
      rd_tlbidx_q  <= '0;
      rd_tlbehi_q  <= '0;
      rd_tlbelo0_q <= '0;
      rd_tlbelo1_q <= '0;
      rd_asid_q    <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_q + 1'b1;
      op_q       <= op_d;
      ptr_q      <= ptr_d;
      if (accept) begin
        tgt_q      <= (op_d == OpFill) ? fill_cnt_q : bus.csr_tlbidx[IW-1:0];
        ps_q       <= bus.csr_tlbidx[29:24];
        ne_q       <= bus.csr_tlbidx[31];
        vppn_q     <= bus.csr_tlbehi[31:13];
        p0_q       <= to_page(bus.csr_tlbelo0);
        p1_q       <= to_page(bus.csr_tlbelo1);
        g_q        <= bus.csr_tlbelo0[6] & bus.csr_tlbelo1[6];
        asid_q     <= bus.csr_asid;
        force_e_q  <= bus.csr_estat_ecode == 6'h3F;
        inv_op_q   <= bus.invtlb_op;
        inv_asid_q <= bus.invtlb_asid[9:0];
        inv_va_q   <= bus.invtlb_va;
      end
      if (state_q == StSrchScan && srch_end) begin
        srch_ne_q  <= !srch_hit;
        srch_idx_q <= srch_hit ? ptr_q : '0;
      end
      if (state_q == StRd) begin
        if (e_q[tgt_q]) begin
          rd_tlbidx_q  <= {2'b00, rd_ent.ps, {(24 - IW){1'b0}}, tgt_q};
          rd_tlbehi_q  <= {rd_ent.vppn, 13'b0};
          rd_tlbelo0_q <= to_elo(rd_ent.p0, rd_ent.g);
          rd_tlbelo1_q <= to_elo(rd_ent.p1, rd_ent.g);
          rd_asid_q    <= rd_ent.asid;
        end else begin
          rd_tlbidx_q  <= 32'h8000_0000;
          rd_tlbehi_q  <= '0;
          rd_tlbelo0_q <= '0;
          rd_tlbelo1_q <= '0;
          rd_asid_q    <= '0;
        end
      end
    end
  end

  assign wr_en   = state_q == StWr;
  assign inv_clr = (state_q == StInvScan) && inv_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          e_q        <= '0;
    else if (wr_en)   e_q[tgt_q] <= force_e_q | ~ne_q;
    else if (inv_clr) e_q[ptr_q] <= 1'b0;
  end

  // Payload only matters while E=1, so it needs no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_q[tgt_q] <= '{vppn: vppn_q, ps: ps_q, g: g_q, asid: asid_q, p0: p0_q, p1: p1_q};
    end
  end

  assign done              = state_q == StDone;
  assign bus.tlbsrch_ready = done && (op_q == OpSrch);
  assign bus.tlbrd_ready   = done && (op_q == OpRd);
  assign bus.tlbwr_ready   = done && (op_q == OpWr);
  assign bus.tlbfill_ready = done && (op_q == OpFill);
  assign bus.invtlb_ready  = done && (op_q == OpInv);

  assign bus.srch_wen   = bus.tlbsrch_ready;
  assign bus.srch_ne    = bus.tlbsrch_ready & srch_ne_q;
  assign bus.srch_idx   = bus.tlbsrch_ready ? srch_idx_q : '0;
  assign bus.rd_wen     = bus.tlbrd_ready;
  assign bus.rd_tlbidx  = bus.tlbrd_ready ? rd_tlbidx_q : '0;
  assign bus.rd_tlbehi  = bus.tlbrd_ready ? rd_tlbehi_q : '0;
  assign bus.rd_tlbelo0 = bus.tlbrd_ready ? rd_tlbelo0_q : '0;
  assign bus.rd_tlbelo1 = bus.tlbrd_ready ? rd_tlbelo1_q : '0;
  assign bus.rd_asid    = bus.tlbrd_ready ? rd_asid_q : '0;
endmodule

// File: doc/tlb_op_unit.md
# tlb_op_unit

Responder for the execute stage's TLB maintenance handshakes (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB). It owns the TLB entry array and performs each operation over one or more cycles. It returns a one-cycle `*_ready` pulse on completion and drives CSR write-back data for SRCH and RD. It sits beside the CSR file, opposite the privileged-instruction sequencer in EX.

## Interface
- `TLB_NUM`, 16: entry count; power of two, 4..32; `IW = log2(TLB_NUM)`.

- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `tlbsrch_valid` / `tlbrd_valid` / `tlbwr_valid` / `tlbfill_valid` / `invtlb_valid` in 1 each: one-cycle request pulses.
- `tlbsrch_ready` / `tlbrd_ready` / `tlbwr_ready` / `tlbfill_ready` / `invtlb_ready` out 1 each: one-cycle completion pulses.
- `invtlb_op` in 5: INVTLB op.
- `invtlb_asid` in 32: INVTLB ASID; bits [9:0] are used.
- `invtlb_va` in 19: INVTLB VPPN.
- `csr_tlbidx` in 32: index [IW-1:0], PS [29:24], NE [31].
- `csr_tlbehi` in 32: VPPN [31:13].
- `csr_tlbelo0`, `csr_tlbelo1` in 32: V[0], D[1], PLV[3:2], MAT[5:4], G[6], PPN[27:8].
- `csr_asid` in 10: current ASID.
- `csr_estat_ecode` in 6: when this equals 0x3F, WR/FILL force E=1.
- `srch_wen` out 1: SRCH write-back strobe.
- `srch_ne` out 1: SRCH write-back NE bit.
- `srch_idx` out IW: SRCH write-back index.
- `rd_wen` out 1: RD write-back strobe.
- `rd_tlbidx` out 32: RD write-back TLBIDX.
- `rd_tlbehi` out 32: RD write-back TLBEHI.
- `rd_tlbelo0`, `rd_tlbelo1` out 32: RD write-back TLBELO0/1.
- `rd_asid` out 10: RD write-back ASID.

## Operation
- Entry fields: E, VPPN[18:0], PS[5:0], G, ASID[9:0], and per page {PPN[19:0], PLV, MAT, D, V}.
- Page-size handling:
  - PS is stored as written.
  - Match on PS==21 compares VPPN[18:9] only.
  - Any other PS compares all 19 bits.
- G is written as `elo0.G & elo1.G`.
- Request capture:
  - Requests are accepted only in IDLE.
  - On accept, the unit latches `csr_*` and `invtlb_*` inputs.
  - Simultaneous valids use priority SRCH > RD > WR > FILL > INV; lower-priority valids are dropped.
  - Valids arriving while busy are ignored.
- FSM states: IDLE, SRCH_SCAN, RD, WR, INV_SCAN, DONE.
  - **IDLE**: srch → SRCH_SCAN with scan ptr=0. rd → RD. wr/fill → WR. inv → INV_SCAN with ptr=0.
  - **SRCH_SCAN**: tests entry[ptr] with E=1, VPPN match against latched ehi, and (G | ASID==latched asid).
    - Hit → DONE with `srch_idx`=ptr, `srch_ne`=0.
    - ptr==TLB_NUM-1 with no hit → DONE with `srch_ne`=1, `srch_idx`=0.
    - Otherwise ptr++.
  - **RD**: reads entry[latched idx] → DONE.
    - E=1: `rd_tlbidx`={NE=0, PS, idx}; ehi, elo, and asid are formatted from the entry.
    - E=0: NE=1; every other `rd_*` field is 0.
  - **WR**: writes entry[target], then → DONE.
    - Target is the latched tlbidx index for WR, or the latched fill counter for FILL.
    - E = (ecode==0x3F) ? 1 : ~NE.
  - **INV_SCAN**: clears E of entry[ptr] if it matches `op`; ptr++. After ptr==TLB_NUM-1 → DONE.
    - op 0/1: all entries.
    - op 2: G=1.
    - op 3: G=0.
    - op 4: G=0 & ASID==asid.
    - op 5: G=0 & ASID==asid & VA match.
    - op 6: (G=1 | ASID==asid) & VA match.
    - Any other op: no entry changes, but the full scan still runs.
  - **DONE**: asserts the matching `*_ready` for one cycle; `srch_wen`/`rd_wen` assert in the same cycle when applicable → IDLE.
- Fill counter: an IW-bit free-running counter, +1 every clock with wrap at TLB_NUM-1→0. It is sampled on the `tlbfill_valid` accept cycle.

## Timing
- Reset (asynchronous):
  - All entries E=0.
  - FSM=IDLE; ptr, fill counter = 0.
  - Every output = 0.
  - Reset mid-operation aborts the operation; no ready is issued.
- Latency, counted from the valid cycle to the ready cycle:
  - RD: 2.
  - WR/FILL: 2; the entry is visible from the ready cycle onward.
  - SRCH: hit at index k → k+2; miss → TLB_NUM+1.
  - INV: always TLB_NUM+1.
- Each ready is a single-cycle pulse. Write-back outputs are 0 outside the DONE cycle.
- The next valid is accepted no earlier than the cycle after ready, i.e. the unit is back in IDLE.

## Test plan
- **WR then RD**: Reset; WR idx=3, ehi VPPN=0x12345, elo0 PPN=0xABCDE V=1, NE=0, ASID=5. Then RD idx=3. Require `rd_tlbidx` NE=0, PS as written, index 3; `rd_tlbehi`[31:13]=0x12345; `rd_asid`=5; each ready 2 cycles after its valid.
- **SRCH latency**: Using the above entry, SRCH hit → `srch_idx`=3, `srch_ne`=0, ready at cycle 5. SRCH with ASID=6 and G=0 → `srch_ne`=1, ready at cycle 17 (TLB_NUM=16).
- **4 MB match**: Entry with PS=21, VPPN=0x40000. SRCH VPPN=0x401FF → hit.
- **INVTLB op 5**: Entries at 2 (G=0, ASID=7) and 4 (G=1, ASID=7), same VA. INVTLB op 5 ASID=7 clears only entry 2; ready 17 cycles after valid. A following RD of entry 2 → NE=1.
- **Simultaneous and busy requests**: FILL and INV valid together → only FILL performed; the written index equals the counter value in the valid cycle. A valid during an INV scan is ignored.
- **Reset mid-operation**: Assert reset during SRCH_SCAN → no ready; a RD afterwards → NE=1.
